regfile_sb: RTL and testbench
=============================

// Module: regfile_sb
// PURPOSE
//  Parametrised multi-port integer register file with a per-register busy scoreboard and optional
//  write-to-read bypass, for the dual-issue core. Sits between decode/issue (reads, busy alloc) and
//  writeback (writes, busy clear). Replaces the fixed 4-read/2-write file; port counts set per build.
// PARAMETERS
//  DATA_W   32  register width in bits
//  NREG     32  number of architectural registers (power of 2); AW = $clog2(NREG)
//  NRD      4   number of read ports
//  NWR      2   number of write ports (also number of busy-alloc ports)
//  BYPASS   1   1: same-cycle write data forwarded to reads; 0: write visible next cycle
//  ZERO_R0  1   1: register 0 hard-wired to zero, never written, never busy
// PORTS
//  clk         in   1          clock, all state updates on rising edge
//  rst         in   1          synchronous reset, active high
//  raddr       in   NRD*AW     read addresses, port i = raddr[i*AW +: AW]
//  rdata       out  NRD*DATA_W read data, port i = rdata[i*DATA_W +: DATA_W]
//  rbusy       out  NRD        1 = register at raddr[i] awaiting writeback
//  we          in   NWR        write enables
//  waddr       in   NWR*AW     write addresses
//  wdata       in   NWR*DATA_W write data
//  alloc_en    in   NWR        mark destination busy (issue)
//  alloc_addr  in   NWR*AW     destination addresses to mark busy
//  flush       in   1          clear all busy bits (pipeline flush)
// BEHAVIOUR
//  - Reset: rst=1 at a rising edge clears all NREG registers to 0 and all busy bits to 0, regardless
//    of we/alloc_en that cycle. rdata/rbusy are combinational and follow from cleared state.
//  - Reads combinational, zero latency: rdata[i] = reg[raddr[i]], rbusy[i] = busy[raddr[i]].
//  - BYPASS=1: if any we[j] with waddr[j]==raddr[i] this cycle, rdata[i]=wdata[j] (highest such j)
//    and rbusy[i]=0. BYPASS=0: no forwarding; rdata[i] shows old value until next edge.
//  - ZERO_R0=1: raddr==0 -> rdata=0, rbusy=0 always; writes/allocs to reg 0 ignored, never bypassed.
//  - Write: on rising edge, reg[waddr[j]] <= wdata[j] for each we[j]. Same address on several ports:
//    highest port index wins (port index = program order, higher = younger).
//  - Busy next state per register r, evaluated in priority order (highest first):
//    1. rst -> 0;  2. alloc_en[k] && alloc_addr[k]==r (any k) -> 1;  3. flush -> 0;
//    4. we[j] && waddr[j]==r (any j) -> 0;  5. else hold.
//    Alloc beats same-cycle write to same reg (newer producer pending). Alloc beats flush (issue of
//    the first post-flush instruction may coincide with flush).
//  - Alloc does not affect rbusy in the same cycle; visible from next cycle.
//  - flush does not cancel writes: we in a flush cycle still update the register array.
//  - Write to a non-busy register is legal: data updated, busy stays 0.
//  - No internal FSM beyond per-register state; no stalls; all ports always ready.
// TESTING
//  1. rst=1 one cycle after random writes -> all rdata=0, rbusy=0 for every address.
//  2. we[0]=1 waddr=5 wdata=0xDEADBEEF, raddr[0]=5 same cycle -> BYPASS=1: rdata=0xDEADBEEF;
//     BYPASS=0: old value, then 0xDEADBEEF next cycle.
//  3. we[0],we[1] both waddr=7, wdata 0x11/0x22 -> next cycle reg7=0x22.
//  4. alloc_en[0] addr=9 -> next cycle rbusy=1 on 9; we[1] addr=9 with alloc_en[1] addr=9 same cycle
//     -> stays busy; later lone write -> rbusy=0 next cycle.
//  5. busy on regs 3,4, flush=1 with alloc_en[0] addr=4 -> next cycle busy3=0, busy4=1.
//  6. ZERO_R0=1: we addr=0 data=0xFFFFFFFF, alloc addr=0 -> rdata for raddr=0 stays 0, rbusy=0.

Source files
------------

// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - bus bundle for the scoreboarded register file
//
// Purpose: groups the issue/writeback side of regfile_sb into one interface.
// Ports (all packed, port i at [i*W +: W]):
//   raddr      NRD*AW      read addresses           (master -> slave)
//   rdata      NRD*DATA_W  read data                (slave -> master)
//   rbusy      NRD         register awaiting wb     (slave -> master)
//   we         NWR         write enables            (master -> slave)
//   waddr      NWR*AW      write addresses          (master -> slave)
//   wdata      NWR*DATA_W  write data               (master -> slave)
//   alloc_en   NWR         mark destination busy    (master -> slave)
//   alloc_addr NWR*AW      destinations to mark     (master -> slave)
//   flush      1           clear all busy bits      (master -> slave)
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 4,
  parameter int NWR    = 2
);
  localparam int AW = $clog2(NREG);

  logic [NRD*AW-1:0]     raddr;
  logic [NRD*DATA_W-1:0] rdata;
  logic [NRD-1:0]        rbusy;
  logic [NWR-1:0]        we;
  logic [NWR*AW-1:0]     waddr;
  logic [NWR*DATA_W-1:0] wdata;
  logic [NWR-1:0]        alloc_en;
  logic [NWR*AW-1:0]     alloc_addr;
  logic                  flush;

  modport master (
    output raddr, we, waddr, wdata, alloc_en, alloc_addr, flush,
    input  rdata, rbusy
  );

  modport slave (
    input  raddr, we, waddr, wdata, alloc_en, alloc_addr, flush,
    output rdata, rbusy
  );
endinterface

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-port register file with busy scoreboard and bypass
//
// Purpose: NREG x DATA_W register file, NRD combinational read ports, NWR
// write ports, and one busy bit per register set by issue (alloc) and cleared
// by writeback or flush.
// Ports:
//   clk  in  clock, all state updates on rising edge
//   rst  in  synchronous reset, active high
//   bus  regfile_sb_if.slave - read/write/alloc/flush bundle
module regfile_sb #(
  parameter int DATA_W  = 32,
  parameter int NREG    = 32,
  parameter int NRD     = 4,
  parameter int NWR     = 2,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 1
) (
  input  logic        clk,
  input  logic        rst,
  regfile_sb_if.slave bus
);
  localparam int AW = $clog2(NREG);

  logic [DATA_W-1:0]     r_regs [NREG];
  logic [NREG-1:0]       r_busy;
  logic [NREG-1:0]       w_busy_nxt;
  logic [NRD*DATA_W-1:0] w_rdata;
  logic [NRD-1:0]        w_rbusy;

  // Rules are applied from lowest to highest priority so later ones override:
  // writeback clear, then flush clear, then alloc set.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int r = 0; r < NREG; r++) begin
      for (int j = 0; j < NWR; j++) begin
        if (bus.we[j] && bus.waddr[j*AW +: AW] == AW'(r)) w_busy_nxt[r] = 1'b0;
      end
      if (bus.flush) w_busy_nxt[r] = 1'b0;
      for (int k = 0; k < NWR; k++) begin
        if (bus.alloc_en[k] && bus.alloc_addr[k*AW +: AW] == AW'(r)) w_busy_nxt[r] = 1'b1;
      end
      if (ZERO_R0 != 0 && r == 0) w_busy_nxt[r] = 1'b0;
    end
  end

  // Ascending port loop: the last non-blocking write wins, so the highest
  // (youngest) port takes a shared address.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) r_regs[r] <= '0;
      r_busy <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (bus.we[j] && !(ZERO_R0 != 0 && bus.waddr[j*AW +: AW] == '0)) begin
          r_regs[bus.waddr[j*AW +: AW]] <= bus.wdata[j*DATA_W +: DATA_W];
        end
      end
      r_busy <= w_busy_nxt;
    end
  end

  // Reads: array value, optionally overridden by same-cycle write data
  // (highest matching port last), with register 0 forced to zero / not busy.
  always_comb begin
    w_rdata = '0;
    w_rbusy = '0;
    for (int i = 0; i < NRD; i++) begin
      w_rdata[i*DATA_W +: DATA_W] = r_regs[bus.raddr[i*AW +: AW]];
      w_rbusy[i]                  = r_busy[bus.raddr[i*AW +: AW]];
      if (BYPASS != 0) begin
        for (int j = 0; j < NWR; j++) begin
          if (bus.we[j] && bus.waddr[j*AW +: AW] == bus.raddr[i*AW +: AW]) begin
            w_rdata[i*DATA_W +: DATA_W] = bus.wdata[j*DATA_W +: DATA_W];
            w_rbusy[i]                  = 1'b0;
          end
        end
      end
      if (ZERO_R0 != 0 && bus.raddr[i*AW +: AW] == '0) begin
        w_rdata[i*DATA_W +: DATA_W] = '0;
        w_rbusy[i]                  = 1'b0;
      end
    end
  end

  assign bus.rdata = w_rdata;
  assign bus.rbusy = w_rbusy;
endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed self-checking bench for regfile_sb
module tb_regfile_sb;
  localparam int DATA_W = 32;
  localparam int NREG   = 32;
  localparam int NRD    = 4;
  localparam int NWR    = 2;
  localparam int AW     = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  regfile_sb_if #(.DATA_W(DATA_W), .NREG(NREG), .NRD(NRD), .NWR(NWR)) bus ();

  regfile_sb #(
    .DATA_W(DATA_W), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1), .ZERO_R0(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.we         = '0;
    bus.waddr      = '0;
    bus.wdata      = '0;
    bus.alloc_en   = '0;
    bus.alloc_addr = '0;
    bus.flush      = 1'b0;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    bus.raddr[p*AW +: AW] = a;
  endtask

  task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [DATA_W-1:0] d);
    bus.we[p]                  = 1'b1;
    bus.waddr[p*AW +: AW]      = a;
    bus.wdata[p*DATA_W +: DATA_W] = d;
  endtask

  task automatic set_alloc(input int p, input logic [AW-1:0] a);
    bus.alloc_en[p]            = 1'b1;
    bus.alloc_addr[p*AW +: AW] = a;
  endtask

  function automatic logic [DATA_W-1:0] rd(input int p);
    return bus.rdata[p*DATA_W +: DATA_W];
  endfunction

  initial begin
    clear_inputs();
    bus.raddr = '0;
    tick();
    rst = 1'b0;

    // Test 1: fill some registers and busy bits, then reset with activity.
    set_wr(0, 5'd3, 32'hCAFE0003);
    set_wr(1, 5'd17, 32'hCAFE0017);
    set_alloc(0, 5'd20);
    set_alloc(1, 5'd21);
    tick();
    clear_inputs();
    set_rd(0, 5'd3);
    #1;
    check("pre_rst_r3", rd(0), 64'hCAFE0003);
    rst = 1'b1;
    set_wr(0, 5'd3, 32'h12345678);
    set_alloc(0, 5'd3);
    tick();
    rst = 1'b0;
    clear_inputs();
    for (int a = 0; a < NREG; a++) begin
      for (int p = 0; p < NRD; p++) set_rd(p, AW'(a));
      #1;
      check("rst_rdata", rd(a % NRD), 64'h0);
      check("rst_rbusy", bus.rbusy[a % NRD], 64'h0);
    end

    // Test 2: same-cycle bypass, then stored value.
    set_rd(0, 5'd5);
    set_rd(1, 5'd5);
    #1;
    check("r5_before", rd(0), 64'h0);
    set_wr(0, 5'd5, 32'hDEADBEEF);
    #1;
    check("bypass_r5", rd(0), 64'hDEADBEEF);
    check("bypass_r5_p1", rd(1), 64'hDEADBEEF);
    tick();
    clear_inputs();
    #1;
    check("stored_r5", rd(0), 64'hDEADBEEF);

    // Test 3: two writes to reg 7, highest port wins (bypass and storage).
    set_rd(0, 5'd7);
    set_wr(0, 5'd7, 32'h11);
    set_wr(1, 5'd7, 32'h22);
    #1;
    check("bypass_prio_r7", rd(0), 64'h22);
    tick();
    clear_inputs();
    #1;
    check("stored_r7", rd(0), 64'h22);
    set_rd(2, 5'd5);
    set_rd(3, 5'd7);
    #1;
    check("p2_r5", rd(2), 64'hDEADBEEF);
    check("p3_r7", rd(3), 64'h22);

    // Test 4: alloc, alloc beats write, lone write clears.
    set_rd(0, 5'd9);
    set_alloc(0, 5'd9);
    #1;
    check("alloc_same_cycle", bus.rbusy[0], 64'h0);
    tick();
    clear_inputs();
    #1;
    check("alloc_busy9", bus.rbusy[0], 64'h1);
    set_wr(1, 5'd9, 32'h99);
    set_alloc(1, 5'd9);
    #1;
    check("bypass_clears_rbusy", bus.rbusy[0], 64'h0);
    check("bypass_r9", rd(0), 64'h99);
    tick();
    clear_inputs();
    #1;
    check("alloc_beats_wr", bus.rbusy[0], 64'h1);
    check("r9_written", rd(0), 64'h99);
    set_wr(0, 5'd9, 32'hAA);
    tick();
    clear_inputs();
    #1;
    check("wr_clears_busy9", bus.rbusy[0], 64'h0);
    check("r9_lone_wr", rd(0), 64'hAA);

    // Test 5: flush clears busy 3, alloc 4 survives flush; write in flush lands.
    set_alloc(0, 5'd3);
    set_alloc(1, 5'd4);
    tick();
    clear_inputs();
    set_rd(0, 5'd3);
    set_rd(1, 5'd4);
    set_rd(2, 5'd12);
    #1;
    check("busy3_set", bus.rbusy[0], 64'h1);
    check("busy4_set", bus.rbusy[1], 64'h1);
    bus.flush = 1'b1;
    set_alloc(0, 5'd4);
    set_wr(1, 5'd12, 32'h1212);
    tick();
    clear_inputs();
    #1;
    check("flush_busy3", bus.rbusy[0], 64'h0);
    check("alloc_beats_flush4", bus.rbusy[1], 64'h1);
    check("flush_keeps_wr12", rd(2), 64'h1212);
    check("nonbusy_wr12_busy", bus.rbusy[2], 64'h0);

    // Test 6: register 0 hard-wired.
    set_rd(0, 5'd0);
    set_wr(0, 5'd0, 32'hFFFFFFFF);
    set_alloc(0, 5'd0);
    #1;
    check("r0_no_bypass", rd(0), 64'h0);
    check("r0_rbusy_now", bus.rbusy[0], 64'h0);
    tick();
    clear_inputs();
    #1;
    check("r0_data", rd(0), 64'h0);
    check("r0_rbusy", bus.rbusy[0], 64'h0);

    // Final reset clears data and pending busy.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_rd(0, 5'd4);
    set_rd(1, 5'd5);
    #1;
    check("rst2_busy4", bus.rbusy[0], 64'h0);
    check("rst2_r5", rd(1), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
